// File: rtl/frame_buffer_write_ctrl.sv
`timescale 1ns/1ps
// Write-side controller for the 320x240 12-bit frame buffer: handshake, address generation, geometry policing.
// Define FB_DOUBLE_BUFFER_EN to build the ping-pong bank pair and its WAIT_SWAP state.
module frame_buffer_write_ctrl #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 12
) (
  input  logic              piul1Clock,
  input  logic              piul1Reset,
  input  logic              piul1Valid,
  output logic              poul1Ready,
  input  logic [DATA_W-1:0] piul12Data,
  input  logic              piul1StartOfFrame,
  input  logic              piul1EndOfLine,
  input  logic              piul1BankRelease,
  output logic              poul1WEnable,
  output logic [ADDR_W-1:0] poul17WAddr,
  output logic [DATA_W-1:0] poul12WData,
  output logic              poul1WBank,
  output logic              poul1RBank,
  output logic              poul1FrameDone,
  output logic              poul1FormatErr
);

  localparam logic [8:0]        COL_FULL  = 9'(H_PIXELS);
  localparam logic [8:0]        COL_LAST  = 9'(H_PIXELS - 1);
  localparam logic [7:0]        ROW_LAST  = 8'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    WRITE     = 2'd1
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    WAIT_SWAP = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              long_q, long_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;
  logic [ADDR_W-1:0] pix_addr;

`ifdef FB_DOUBLE_BUFFER_EN
  logic wbank_q, wbank_d;
  logic rbank_q, rbank_d;

  assign poul1Ready = (state_q != WAIT_SWAP);
  assign poul1WBank = wbank_q;
  assign poul1RBank = rbank_q;
`else
  logic unused_release;

  assign unused_release = piul1BankRelease;
  assign poul1Ready     = 1'b1;
  assign poul1WBank     = 1'b0;
  assign poul1RBank     = 1'b0;
`endif

  assign xfer     = piul1Valid & poul1Ready;
  assign pix_addr = base_q + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    long_d  = long_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
    wbank_d = wbank_q;
    rbank_d = rbank_q;
`endif
    case (state_q)
      WAIT_SOF: begin
        if (xfer && piul1StartOfFrame) begin
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = piul12Data;
          col_d   = 9'd1;
          row_d   = '0;
          base_d  = '0;
          long_d  = 1'b0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (xfer) begin
          if (piul1StartOfFrame) begin
            err_d   = 1'b1;
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = piul12Data;
            col_d   = 9'd1;
            row_d   = '0;
            base_d  = '0;
            long_d  = 1'b0;
          end else if (piul1EndOfLine) begin
            // A long line already reported its error; the closing EOL stays quiet.
            err_d = (col_q != COL_LAST) && !long_q;
            if (col_q != COL_FULL) begin
              we_d    = 1'b1;
              waddr_d = pix_addr;
              wdata_d = piul12Data;
            end
            col_d  = '0;
            row_d  = row_q + 8'd1;
            base_d = base_q + LINE_STEP;
            long_d = 1'b0;
            if (row_q == ROW_LAST) begin
              done_d = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
              state_d = WAIT_SWAP;
`else
              state_d = WAIT_SOF;
`endif
            end
          end else if (col_q == COL_FULL) begin
            err_d  = !long_q;
            long_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = pix_addr;
            wdata_d = piul12Data;
            col_d   = col_q + 9'd1;
          end
        end
      end
`ifdef FB_DOUBLE_BUFFER_EN
      WAIT_SWAP: begin
        if (piul1BankRelease) begin
          rbank_d = wbank_q;
          wbank_d = ~wbank_q;
          state_d = WAIT_SOF;
        end
      end
`endif
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge piul1Clock or posedge piul1Reset) begin
    if (piul1Reset) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      long_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      wbank_q <= 1'b0;
      rbank_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      long_q  <= long_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef FB_DOUBLE_BUFFER_EN
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
`endif
    end
  end

  assign poul1WEnable   = we_q;
  assign poul17WAddr    = waddr_q;
  assign poul12WData    = wdata_q;
  assign poul1FrameDone = done_q;
  assign poul1FormatErr = err_q;

endmodule

// File: tb/tb_frame_buffer_write_ctrl.sv
`timescale 1ns/1ps
// Randomised bench for frame_buffer_write_ctrl; a pixel-position model predicts every registered output.
module tb_frame_buffer_write_ctrl;

  localparam int H  = 320;
  localparam int V  = 240;
  localparam int AW = 17;
  localparam int DW = 12;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          valid = 1'b0;
  logic          sof   = 1'b0;
  logic          eol   = 1'b0;
  logic          rel   = 1'b0;
  logic [DW-1:0] data  = '0;
  logic          ready, we, wbank, rbank, done, ferr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int checks = 0;
  int errors = 0;
  int obs_we = 0, obs_err = 0, obs_done = 0, done_addr = -1;

  always #5 clk = ~clk;

  frame_buffer_write_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .piul1Clock(clk), .piul1Reset(rst), .piul1Valid(valid), .poul1Ready(ready),
    .piul12Data(data), .piul1StartOfFrame(sof), .piul1EndOfLine(eol),
    .piul1BankRelease(rel), .poul1WEnable(we), .poul17WAddr(waddr),
    .poul12WData(wdata), .poul1WBank(wbank), .poul1RBank(rbank),
    .poul1FrameDone(done), .poul1FormatErr(ferr)
  );

  // Model: where in the frame the next pixel lands, as line/position counts.
  typedef struct packed {
    bit in_frame;
    bit await_rel;
    bit reported;
    int line;
    int pos;
    bit wbank;
    bit rbank;
    bit we;
    bit done;
    bit err;
    int addr;
    int data;
  } mdl_t;

  function automatic mdl_t rst_mdl();
    mdl_t n;
    n = '0;
    n.rbank = DB;
    return n;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit v, input bit s, input bit e,
                                input bit r, input int d);
    mdl_t n;
    n = m;
    n.we = 0; n.done = 0; n.err = 0;
    if (m.await_rel) begin
      if (r) begin n.rbank = m.wbank; n.wbank = !m.wbank; n.await_rel = 0; end
    end else if (v) begin
      if (s) begin
        n.err = m.in_frame; n.in_frame = 1; n.line = 0; n.pos = 1; n.reported = 0;
        n.we = 1; n.addr = 0; n.data = d;
      end else if (m.in_frame) begin
        if (m.pos < H) begin n.we = 1; n.addr = m.line * H + m.pos; n.data = d; end
        if (e) begin
          n.err = (m.pos != H - 1) && !m.reported;
          n.line = m.line + 1; n.pos = 0; n.reported = 0;
          if (m.line == V - 1) begin n.done = 1; n.in_frame = 0; n.await_rel = DB; end
        end else begin
          if (m.pos >= H && !m.reported) begin n.err = 1; n.reported = 1; end
          n.pos = m.pos + 1;
        end
      end
    end
    return n;
  endfunction

  mdl_t mdl = rst_mdl();

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= rst_mdl();
    else     mdl <= step(mdl, valid, sof, eol, rel, int'(data));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready", int'(ready), int'(!mdl.await_rel));
    chk("wenable", int'(we), int'(mdl.we));
    if (mdl.we) begin
      chk("waddr", int'(waddr), mdl.addr);
      chk("wdata", int'(wdata), mdl.data);
    end
    chk("frame_done", int'(done), int'(mdl.done));
    chk("format_err", int'(ferr), int'(mdl.err));
    chk("wbank", int'(wbank), int'(mdl.wbank));
    chk("rbank", int'(rbank), int'(mdl.rbank));
    if (we)   obs_we++;
    if (ferr) obs_err++;
    if (done) begin obs_done++; done_addr = int'(waddr); end
  end

  task automatic send(input bit s, input bit e);
    int guard = 0;
    valid = 1'b1; sof = s; eol = e; data = DW'($urandom_range(0, (1 << DW) - 1));
    while (ready !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready %b required 1", ready);
    end
    @(posedge clk); #1;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b1;
    #6; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_we, b_err, b_done;
    #1; rst = 1'b1; #2;
    chk("rst_ready", int'(ready), 1);
    chk("rst_wenable", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_wbank", int'(wbank), 0);
    chk("rst_rbank", int'(rbank), int'(DB));
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(ferr), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;

    // Short line: line 5 carries 300 pixels.
    do_reset();
    b_err = obs_err;
    for (int l = 0; l < 6; l++) begin
      int n;
      n = (l == 5) ? 300 : H;
      for (int p = 0; p < n; p++) send(l == 0 && p == 0, p == n - 1);
    end
    send(1'b0, 1'b0);
    chk("short_next_we", int'(we), 1);
    chk("short_next_addr", int'(waddr), 1920);
    idle(2);
    chk("short_err_count", obs_err - b_err, 1);

    // Long line: line 0 carries 330 pixels.
    do_reset();
    b_we = obs_we; b_err = obs_err;
    for (int p = 0; p < 330; p++) send(p == 0, p == 329);
    idle(2);
    chk("long_writes", obs_we - b_we, 320);
    chk("long_err_count", obs_err - b_err, 1);
    send(1'b0, 1'b0);
    chk("long_next_addr", int'(waddr), 320);

    // Backpressure, restart at pixel 1000, async reset at address 4000.
    do_reset();
    send(1'b1, 1'b0);
    for (int p = 1; p < 1000; p++) begin
      idle($urandom_range(0, 1));
      send(1'b0, (p % H) == H - 1);
    end
    send(1'b1, 1'b0);
    chk("restart_err", int'(ferr), 1);
    chk("restart_addr", int'(waddr), 0);
    chk("restart_wbank", int'(wbank), 0);
    for (int p = 1; p <= 4000; p++) send(1'b0, (p % H) == H - 1);
    chk("pre_reset_addr", int'(waddr), 4000);
    chk("pre_reset_we", int'(we), 1);
    #2; rst = 1'b1;
    #1;
    chk("async_rst_we", int'(we), 0);
    chk("async_rst_ready", int'(ready), 1);
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    b_we = obs_we;
    for (int i = 0; i < 5; i++) send(1'b0, i == 2);
    idle(1);
    chk("post_reset_discard", obs_we - b_we, 0);
    send(1'b1, 1'b0);
    chk("post_reset_sof_addr", int'(waddr), 0);

    // Clean full frame, with releases during WRITE and on the final EOL.
    do_reset();
    b_we = obs_we; b_err = obs_err; b_done = obs_done;
    for (int l = 0; l < V; l++) begin
      for (int p = 0; p < H; p++) begin
        rel = (l == 100 && p == 0) || (l == V - 1 && p == H - 1);
        send(l == 0 && p == 0, p == H - 1);
        rel = 1'b0;
      end
    end
    idle(3);
    chk("frame_writes", obs_we - b_we, V * H);
    chk("frame_errs", obs_err - b_err, 0);
    chk("frame_done_count", obs_done - b_done, 1);
    chk("frame_done_addr", done_addr, V * H - 1);
    chk("after_frame_ready", int'(ready), int'(!DB));
    chk("after_frame_wbank", int'(wbank), 0);
    chk("after_frame_rbank", int'(rbank), int'(DB));
    rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0;
    chk("swap_wbank", int'(wbank), int'(DB));
    chk("swap_rbank", int'(rbank), 0);
    chk("swap_ready", int'(ready), 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
